z3_bus_master: RTL and testbench

Zorro III bus initiator for the A4092 card. It converts single-longword transfer requests from the on-card DMA engine into complete bus master cycles. Each cycle runs arbitration (BR_n/BG_n/BGACK_n), the address phase, FCS_n, DS_n and the wait for slave DTACK_n or BERR_n. It is the initiator counterpart of the card's slave responders (ROM/register decode), and bounds every wait with a timeout.

---
 rtl/z3_bus_master.sv | 242 ++++++++++++++++++++++++
 tb/tb_z3_bus_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z3_bus_master.sv
// z3_bus_master: Zorro III bus initiator for the A4092 card.
// Turns single-longword DMA requests into complete bus master cycles:
// arbitration, address phase, FCS_n/DS_n strobes, then a wait for
// DTACK_n/BERR_n that is bounded by a timeout. All outputs are registered.
module z3_bus_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  input  logic [29:0] req_addr,
  input  logic        req_write,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        req_ack,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        BR_n,
  input  logic        BG_n,
  output logic        BGACK_n,
  output logic        ADDR_OE,
  output logic [29:0] A_OUT,
  output logic        READ,
  output logic        FCS_n,
  output logic [3:0]  DS_n,
  output logic [31:0] D_OUT,
  output logic        D_OE,
  input  logic [31:0] D_IN,
  input  logic        DTACK_n,
  input  logic        BERR_n
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_ADDR, S_STROBE, S_WAIT, S_TERM, S_REL
  } state_t;

  // Synchronizer chains; bit 1 is the synchronized value, idle-high.
  logic [1:0] bg_sync_q, dtack_sync_q, berr_sync_q;
  logic       bg_s, dtack_s, berr_s;

  assign bg_s    = bg_sync_q[1];
  assign dtack_s = dtack_sync_q[1];
  assign berr_s  = berr_sync_q[1];

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [29:0]    lat_addr_q, lat_addr_d;
  logic           lat_write_q, lat_write_d;
  logic [3:0]     lat_be_q, lat_be_d;
  logic [31:0]    lat_wdata_q, lat_wdata_d;

  logic           req_ack_q, req_ack_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           br_n_q, br_n_d;
  logic           bgack_n_q, bgack_n_d;
  logic           addr_oe_q, addr_oe_d;
  logic [29:0]    a_out_q, a_out_d;
  logic           read_q, read_d;
  logic           fcs_n_q, fcs_n_d;
  logic [3:0]     ds_n_q, ds_n_d;
  logic [31:0]    d_out_q, d_out_d;
  logic           d_oe_q, d_oe_d;

  // Two-flop synchronizers for the asynchronous bus inputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bg_sync_q    <= 2'b11;
      dtack_sync_q <= 2'b11;
      berr_sync_q  <= 2'b11;
    end else begin
      bg_sync_q    <= {bg_sync_q[0], BG_n};
      dtack_sync_q <= {dtack_sync_q[0], DTACK_n};
      berr_sync_q  <= {berr_sync_q[0], BERR_n};
    end
  end

  // State and registered-output update.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lat_addr_q  <= '0;
      lat_write_q <= 1'b0;
      lat_be_q    <= '0;
      lat_wdata_q <= '0;
      req_ack_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      br_n_q      <= 1'b1;
      bgack_n_q   <= 1'b1;
      addr_oe_q   <= 1'b0;
      a_out_q     <= '0;
      read_q      <= 1'b0;
      fcs_n_q     <= 1'b1;
      ds_n_q      <= 4'hF;
      d_out_q     <= '0;
      d_oe_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_addr_q  <= lat_addr_d;
      lat_write_q <= lat_write_d;
      lat_be_q    <= lat_be_d;
      lat_wdata_q <= lat_wdata_d;
      req_ack_q   <= req_ack_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      br_n_q      <= br_n_d;
      bgack_n_q   <= bgack_n_d;
      addr_oe_q   <= addr_oe_d;
      a_out_q     <= a_out_d;
      read_q      <= read_d;
      fcs_n_q     <= fcs_n_d;
      ds_n_q      <= ds_n_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
    end
  end

  // Next-state and next-output logic for the bus cycle sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_addr_d  = lat_addr_q;
    lat_write_d = lat_write_q;
    lat_be_d    = lat_be_q;
    lat_wdata_d = lat_wdata_q;
    req_ack_d   = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    rdata_d     = rdata_q;
    br_n_d      = br_n_q;
    bgack_n_d   = bgack_n_q;
    addr_oe_d   = addr_oe_q;
    a_out_d     = a_out_q;
    read_d      = read_q;
    fcs_n_d     = fcs_n_q;
    ds_n_d      = ds_n_q;
    d_out_d     = d_out_q;
    d_oe_d      = d_oe_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          lat_addr_d  = req_addr;
          lat_write_d = req_write;
          lat_be_d    = req_be;
          lat_wdata_d = req_wdata;
          req_ack_d   = 1'b1;
          br_n_d      = 1'b0;
          state_d     = S_ARB;
        end
      end
      S_ARB: begin
        br_n_d = 1'b0;
        // Take the bus only once granted and the previous slave has let go.
        if (!bg_s && dtack_s) begin
          bgack_n_d = 1'b0;
          br_n_d    = 1'b1;
          addr_oe_d = 1'b1;
          a_out_d   = lat_addr_q;
          read_d    = ~lat_write_q;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        fcs_n_d = 1'b0;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        ds_n_d = ~lat_be_q;
        if (lat_write_q) begin
          d_oe_d  = 1'b1;
          d_out_d = lat_wdata_q;
        end
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Bus error wins over a simultaneous acknowledge.
        if (!berr_s) begin
          err_d   = 1'b1;
          state_d = S_TERM;
        end else if (!dtack_s) begin
          err_d = 1'b0;
          if (read_q) begin
            rdata_d = D_IN;
          end
          state_d = S_TERM;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_TERM;
        end
      end
      S_TERM: begin
        fcs_n_d = 1'b1;
        ds_n_d  = 4'hF;
        d_oe_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_REL;
      end
      S_REL: begin
        // Hold the bus until the slave has released its response lines.
        if (dtack_s && berr_s) begin
          addr_oe_d = 1'b0;
          bgack_n_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ack = req_ack_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign BR_n    = br_n_q;
  assign BGACK_n = bgack_n_q;
  assign ADDR_OE = addr_oe_q;
  assign A_OUT   = a_out_q;
  assign READ    = read_q;
  assign FCS_n   = fcs_n_q;
  assign DS_n    = ds_n_q;
  assign D_OUT   = d_out_q;
  assign D_OE    = d_oe_q;

endmodule

// File: tb/tb_z3_bus_master.sv
// Bench for z3_bus_master: table of single transfers with a built-in slave,
// plus hand-written reset-abort and back-to-back request sequences.
// Expected {err, rdata} pairs are queued on request and checked on done.
module tb_z3_bus_master;

  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req = 1'b0;
  logic [29:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ack, done, err;
  logic [31:0] rdata;
  logic        BR_n;
  logic        BG_n = 1'b0;
  logic        BGACK_n, ADDR_OE;
  logic [29:0] A_OUT;
  logic        READ, FCS_n;
  logic [3:0]  DS_n;
  logic [31:0] D_OUT;
  logic        D_OE;
  logic [31:0] D_IN = '0;
  logic        DTACK_n = 1'b1;
  logic        BERR_n = 1'b1;

  z3_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .req_addr(req_addr),
    .req_write(req_write), .req_be(req_be), .req_wdata(req_wdata),
    .req_ack(req_ack), .done(done), .err(err), .rdata(rdata),
    .BR_n(BR_n), .BG_n(BG_n), .BGACK_n(BGACK_n), .ADDR_OE(ADDR_OE),
    .A_OUT(A_OUT), .READ(READ), .FCS_n(FCS_n), .DS_n(DS_n),
    .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN), .DTACK_n(DTACK_n),
    .BERR_n(BERR_n)
  );

  always #5 CLK = ~CLK;

  // mode: 0 = DTACK, 1 = no response (timeout), 2 = DTACK and BERR together
  typedef struct {
    logic        wr;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          bg_delay;
    int          mode;
    int          ack_delay;
    logic [31:0] din;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_ds;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  vec_t vecs[6];
  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop_check(input int idx);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_empty: done with no queued expectation (xfer %0d)", idx);
    end else begin
      e = sb_q.pop_front();
      chk("done_err", {31'b0, err}, {31'b0, e.err});
      chk("done_rdata", rdata, e.rdata);
    end
  endtask

  task automatic run_xfer(input int idx, input vec_t v);
    int   ack_n = 0, done_n = 0, start;
    int   ack_c = -1, bg_c = -1, fcs_fall = -1, ds_fall = -1, slv_c = -1;
    int   fcs_rise = -1, rel_c = -1, bgack_rise = -1, done_c = -1;
    int   viol = 0;
    logic prev_fcs = 1'b1, prev_bgack = 1'b1;
    bit   fin = 0;
    exp_t e;
    if (v.bg_delay > 0) begin
      BG_n = 1'b1;
      repeat (3) step();
    end
    start = cyc;
    req_addr  = v.addr;
    req_write = v.wr;
    req_be    = v.be;
    req_wdata = v.wdata;
    req       = 1'b1;
    e.err = v.exp_err;
    e.rdata = v.exp_rdata;
    sb_q.push_back(e);
    for (int k = 0; k < 200 && !fin; k++) begin
      step();
      if (req_ack) begin
        ack_n++;
        ack_c = cyc;
        req = 1'b0;
      end
      if (v.bg_delay > 0 && bg_c < 0 && cyc - start == v.bg_delay) begin
        BG_n = 1'b0;
        bg_c = cyc;
      end
      // BR_n must stay low for the whole arbitration phase.
      if (ack_c >= 0 && BGACK_n === 1'b1 && fcs_fall < 0 && BR_n !== 1'b0) viol++;
      if (prev_bgack && !BGACK_n) prev_bgack = 1'b0;
      else if (!prev_bgack && BGACK_n) begin
        bgack_rise = cyc;
        fin = 1;
      end
      if (prev_fcs && !FCS_n) fcs_fall = cyc;
      if (!prev_fcs && FCS_n) fcs_rise = cyc;
      prev_fcs = FCS_n;
      if (DS_n !== 4'hF && ds_fall < 0) begin
        ds_fall = cyc;
        chk("ds_n_value", {28'b0, DS_n}, {28'b0, v.exp_ds});
      end
      if (DS_n !== 4'hF) begin
        if (FCS_n !== 1'b0) viol++;
        if (D_OE !== v.wr) viol++;
        if (v.wr && D_OUT !== v.wdata) viol++;
      end else if (D_OE !== 1'b0) viol++;
      if (BGACK_n === 1'b0 && (ADDR_OE !== 1'b1 || A_OUT !== v.addr || READ !== !v.wr)) viol++;
      if (BGACK_n === 1'b1 && ADDR_OE !== 1'b0) viol++;
      // Slave response.
      if (fcs_fall >= 0 && slv_c < 0 && v.mode != 1 && cyc - fcs_fall == v.ack_delay) begin
        D_IN = v.din;
        DTACK_n = 1'b0;
        if (v.mode == 2) BERR_n = 1'b0;
        slv_c = cyc;
      end
      if (fcs_rise >= 0 && rel_c < 0 && cyc - fcs_rise == 2) begin
        DTACK_n = 1'b1;
        BERR_n = 1'b1;
        D_IN = '0;
        rel_c = cyc;
      end
      if (done) begin
        done_n++;
        done_c = cyc;
        sb_pop_check(idx);
      end
    end
    DTACK_n = 1'b1;
    BERR_n = 1'b1;
    if (!fin) begin
      n_chk++;
      n_fail++;
      $display("FAIL xfer_timeout: xfer %0d bus not released within 200 cycles", idx);
    end
    chk("req_ack_count", ack_n, 1);
    chk("done_count", done_n, 1);
    chk("bus_protocol_violations", viol, 0);
    chk("ds_after_fcs", ds_fall - fcs_fall, 1);
    chk("done_with_fcs_rise", done_c, fcs_rise);
    if (v.bg_delay == 0) chk("ack_to_fcs", fcs_fall - ack_c, 2);
    else chk("bg_to_fcs", fcs_fall - bg_c, 4);
    if (v.mode != 1) begin
      chk("dtack_to_fcs_rise", fcs_rise - slv_c, 4);
      chk("release_to_bgack", bgack_rise - rel_c, 3);
    end else begin
      chk("timeout_ds_to_done", done_c - ds_fall, TO + 1);
    end
    $display("xfer %0d: wr=%0d addr=%h be=%b err=%0d rdata=%h ack@%0d fcs@%0d..%0d done@%0d",
             idx, v.wr, v.addr, v.be, err, rdata, ack_c, fcs_fall, fcs_rise, done_c);
    repeat (2) step();
  endtask

  initial begin
    int   done_n, ack_n, ds_c, bgack_rise1, br_fall2, fcs_fall, fcs_rise, slv_c;
    logic prev_fcs, prev_bgack, prev_br;
    exp_t e;

    //             wr    addr          be       wdata         bgd mode ad din           eerr  erdata        eds
    vecs[0] = '{1'b0, 30'h0000_0040, 4'hF,    32'h0,        0,  0,  3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4'h0};
    vecs[1] = '{1'b1, 30'h0100_0000, 4'b0011, 32'h1234_5678, 0,  0,  2, 32'h0BAD0BAD, 1'b0, 32'hDEADBEEF, 4'b1100};
    vecs[2] = '{1'b0, 30'h0000_1234, 4'hF,    32'h0,        20, 0,  1, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 4'h0};
    vecs[3] = '{1'b0, 30'h0000_0100, 4'hF,    32'h0,        0,  1,  0, 32'h0,        1'b1, 32'hCAFEF00D, 4'h0};
    vecs[4] = '{1'b0, 30'h0000_0200, 4'hF,    32'h0,        0,  2,  2, 32'h11111111, 1'b1, 32'hCAFEF00D, 4'h0};
    vecs[5] = '{1'b0, 30'h3FFF_FFFF, 4'b1000, 32'h0,        0,  0,  0, 32'hA5A55A5A, 1'b0, 32'hA5A55A5A, 4'b0111};

    // Reset values.
    repeat (3) step();
    chk("rst_BR_n", {31'b0, BR_n}, 32'd1);
    chk("rst_BGACK_n", {31'b0, BGACK_n}, 32'd1);
    chk("rst_FCS_n", {31'b0, FCS_n}, 32'd1);
    chk("rst_DS_n", {28'b0, DS_n}, 32'hF);
    chk("rst_oe", {30'b0, ADDR_OE, D_OE}, 32'd0);
    chk("rst_pulses", {29'b0, req_ack, done, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_A_OUT", {2'b0, A_OUT}, 32'd0);
    chk("rst_D_OUT", D_OUT, 32'd0);
    RESET = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 6; i++) run_xfer(i, vecs[i]);

    // Reset during WAIT aborts the transfer without a done.
    req_addr = 30'h0000_0300;
    req_write = 1'b0;
    req_be = 4'hF;
    req = 1'b1;
    ds_c = -1;
    for (int k = 0; k < 50 && ds_c < 0; k++) begin
      step();
      if (req_ack) req = 1'b0;
      if (DS_n !== 4'hF) ds_c = cyc;
    end
    chk("abort_reached_strobe", {31'b0, ds_c >= 0}, 32'd1);
    repeat (2) step();
    RESET = 1'b1;
    step();
    chk("abort_FCS_n", {31'b0, FCS_n}, 32'd1);
    chk("abort_BGACK_n", {31'b0, BGACK_n}, 32'd1);
    chk("abort_ADDR_OE", {31'b0, ADDR_OE}, 32'd0);
    chk("abort_DS_n", {28'b0, DS_n}, 32'hF);
    chk("abort_BR_n", {31'b0, BR_n}, 32'd1);
    RESET = 1'b0;
    done_n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done) done_n++;
    end
    chk("abort_no_done", done_n, 0);
    chk("abort_rdata_reset", rdata, 32'd0);
    $display("xfer abort: reset during WAIT, dones after reset=%0d", done_n);

    // req held high across two back-to-back transfers.
    e.err = 1'b0;
    e.rdata = 32'h0000_1111;
    sb_q.push_back(e);
    e.rdata = 32'h0000_2222;
    sb_q.push_back(e);
    req_addr = 30'h0000_0400;
    req_write = 1'b0;
    req_be = 4'hF;
    req = 1'b1;
    done_n = 0;
    ack_n = 0;
    bgack_rise1 = -1;
    br_fall2 = -1;
    fcs_fall = -1;
    fcs_rise = -1;
    slv_c = -1;
    prev_fcs = 1'b1;
    prev_bgack = 1'b1;
    prev_br = 1'b1;
    for (int k = 0; k < 150 && !(done_n == 2 && BGACK_n === 1'b1 && ack_n == 2); k++) begin
      step();
      if (req_ack) begin
        ack_n++;
        if (ack_n == 2) req = 1'b0;
      end
      if (!prev_bgack && BGACK_n && bgack_rise1 < 0) bgack_rise1 = cyc;
      if (prev_br && !BR_n && bgack_rise1 >= 0 && br_fall2 < 0) br_fall2 = cyc;
      if (prev_fcs && !FCS_n) begin
        fcs_fall = cyc;
        slv_c = -1;
      end
      if (!prev_fcs && FCS_n) fcs_rise = cyc;
      if (fcs_fall >= 0 && slv_c < 0 && cyc - fcs_fall == 1) begin
        D_IN = (done_n == 0) ? 32'h0000_1111 : 32'h0000_2222;
        DTACK_n = 1'b0;
        slv_c = cyc;
      end
      if (fcs_rise >= 0 && cyc - fcs_rise == 1) begin
        DTACK_n = 1'b1;
        fcs_rise = -1;
      end
      if (done) begin
        done_n++;
        sb_pop_check(100 + done_n);
      end
      prev_fcs = FCS_n;
      prev_bgack = BGACK_n;
      prev_br = BR_n;
    end
    req = 1'b0;
    DTACK_n = 1'b1;
    chk("hold_req_acks", ack_n, 2);
    chk("hold_req_dones", done_n, 2);
    chk("hold_rearb_after_bgack", br_fall2 - bgack_rise1, 1);
    $display("xfer hold: acks=%0d dones=%0d bgack_rise=%0d br_refall=%0d", ack_n, done_n, bgack_rise1, br_fall2);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
